// File: rtl/ghost_dist_map.sv
// ghost_dist_map
//   Builds a distance-to-pacman map over the maze by repeated relaxation
//   sweeps against the wall ROM. It then serves registered reads from the last
//   completed bank while the next map is built in the other bank.
//
// Ports
//   CLOCK_50                   system clock
//   reset                      asynchronous, active-low reset
//   curr_pacman_x/y            pacman tile, used as the distance-0 seed
//   prev_ghost1_x/y, 2_x/y     ghost previous tiles, always read back as 255
//   rdaddr_x/y                 read tile, sampled on every clock edge
//   data                       distance of the tile addressed on the previous
//                              cycle (255 = unreachable, blocked, or no map)
//   ready                      a completed map is being served
//   busy                       a build is in progress
//   build_done                 1-cycle pulse after the bank swap
//   wall_x/y, wall_in          wall ROM address and its wall bit, which lags
//                              the address by one cycle
//   dbg_state                  current FSM state
//
// There is no valid/ready handshake. A read is issued every cycle, and data
// always reflects the address sampled on the previous edge. 'ready' is a
// status bit and does not throttle reads.
module ghost_dist_map #(
    parameter int GRID_W     = 40,
    parameter int GRID_H     = 30,
    parameter int MAX_SWEEPS = 64
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [5:0] curr_pacman_x,
    input  logic [4:0] curr_pacman_y,
    input  logic [5:0] prev_ghost1_x,
    input  logic [4:0] prev_ghost1_y,
    input  logic [5:0] prev_ghost2_x,
    input  logic [4:0] prev_ghost2_y,
    input  logic [5:0] rdaddr_x,
    input  logic [4:0] rdaddr_y,
    output logic [7:0] data,
    output logic       ready,
    output logic       busy,
    output logic       build_done,
    output logic [5:0] wall_x,
    output logic [4:0] wall_y,
    input  logic       wall_in,
    output logic [2:0] dbg_state
);

    localparam logic [5:0] X_END      = 6'(GRID_W);
    localparam logic [4:0] Y_END      = 5'(GRID_H);
    localparam logic [5:0] X_LAST     = 6'(GRID_W - 1);
    localparam logic [4:0] Y_LAST     = 5'(GRID_H - 1);
    localparam logic [7:0] LAST_SWEEP = 8'(MAX_SWEEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SEED  = 3'd2,
        S_SWEEP = 3'd3,
        S_SWAP  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] clr_cnt_q, clr_cnt_d;
    logic [5:0]  seed_x_q, seed_x_d, rd_seed_x_q, rd_seed_x_d, tile_x_q, tile_x_d;
    logic [4:0]  seed_y_q, seed_y_d, rd_seed_y_q, rd_seed_y_d, tile_y_q, tile_y_d;
    logic [2:0]  phase_q, phase_d;
    logic        dir_q, dir_d, changed_q, changed_d, rd_bank_q, rd_bank_d;
    logic [7:0]  sweep_cnt_q, sweep_cnt_d, self_q, self_d, min_q, min_d;
    logic [7:0]  data_q, data_d;
    logic        ready_q, ready_d, busy_q, busy_d, build_done_q, build_done_d;

    // Both banks live in one array; the top address bit selects the bank.
    logic [7:0]  map_mem [0:4095];
    logic        mem_we;
    logic [11:0] mem_waddr;
    logic [7:0]  mem_wdata;

    logic        build_bank, start_build, tile_is_last, stop_sweeps, wr_now;
    logic [5:0]  nb_x;
    logic [4:0]  nb_y;
    logic        nb_oob;
    logic [7:0]  nb_val, step_val, new_val;

    assign build_bank = ~rd_bank_q;
    assign start_build = !ready_q || (curr_pacman_x != rd_seed_x_q) ||
                         (curr_pacman_y != rd_seed_y_q);

    // Sweep datapath. Phase 0 reads the tile itself; phases 1-4 read its
    // up/down/left/right neighbours; phase 5 decides whether to write.
    // wall_x/y follow the tile for the whole 6-cycle slot, so the ROM bit is
    // settled for the current tile by phase 5.
    always_comb begin
        nb_x   = tile_x_q;
        nb_y   = tile_y_q;
        nb_oob = 1'b0;
        case (phase_q)
            3'd1: begin nb_y = tile_y_q - 5'd1; nb_oob = (tile_y_q == 5'd0);   end
            3'd2: begin nb_y = tile_y_q + 5'd1; nb_oob = (tile_y_q == Y_LAST); end
            3'd3: begin nb_x = tile_x_q - 6'd1; nb_oob = (tile_x_q == 6'd0);   end
            3'd4: begin nb_x = tile_x_q + 6'd1; nb_oob = (tile_x_q == X_LAST); end
            default: ;
        endcase
        nb_val = nb_oob ? 8'hFF : map_mem[{build_bank, nb_y, nb_x}];
        // 255 means "no path", so 255 stays 255; real distances saturate at 254.
        if (min_q == 8'hFF)       step_val = 8'hFF;
        else if (min_q >= 8'd254) step_val = 8'd254;
        else                      step_val = min_q + 8'd1;
        if (wall_in)                                             new_val = 8'hFF;
        else if (tile_x_q == seed_x_q && tile_y_q == seed_y_q)   new_val = 8'd0;
        else                                                     new_val = step_val;
        wr_now       = (state_q == S_SWEEP) && (phase_q == 3'd5) && (new_val < self_q);
        tile_is_last = dir_q ? (tile_x_q == 6'd0 && tile_y_q == 5'd0)
                             : (tile_x_q == X_LAST && tile_y_q == Y_LAST);
        stop_sweeps  = !(changed_q || wr_now) || (sweep_cnt_q == LAST_SWEEP);
    end

    // FSM state register
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_build) state_d = S_CLEAR;
            S_CLEAR: if (clr_cnt_q == 11'h7FF) state_d = S_SEED;
            S_SEED:  state_d = S_SWEEP;
            S_SWEEP: if (phase_q == 3'd5 && tile_is_last && stop_sweeps) state_d = S_SWAP;
            S_SWAP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs and datapath controls
    always_comb begin
        clr_cnt_d    = clr_cnt_q;
        seed_x_d     = seed_x_q;
        seed_y_d     = seed_y_q;
        rd_seed_x_d  = rd_seed_x_q;
        rd_seed_y_d  = rd_seed_y_q;
        tile_x_d     = tile_x_q;
        tile_y_d     = tile_y_q;
        phase_d      = phase_q;
        dir_d        = dir_q;
        changed_d    = changed_q;
        sweep_cnt_d  = sweep_cnt_q;
        self_d       = self_q;
        min_d        = min_q;
        rd_bank_d    = rd_bank_q;
        ready_d      = ready_q;
        busy_d       = busy_q;
        build_done_d = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = 12'd0;
        mem_wdata    = 8'd0;
        case (state_q)
            S_IDLE: begin
                if (start_build) begin
                    seed_x_d  = curr_pacman_x;
                    seed_y_d  = curr_pacman_y;
                    busy_d    = 1'b1;
                    clr_cnt_d = 11'd0;
                end
            end
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = {build_bank, clr_cnt_q};
                mem_wdata = 8'hFF;
                clr_cnt_d = clr_cnt_q + 11'd1;
            end
            S_SEED: begin
                mem_we      = 1'b1;
                mem_waddr   = {build_bank, seed_y_q, seed_x_q};
                mem_wdata   = 8'd0;
                tile_x_d    = 6'd0;
                tile_y_d    = 5'd0;
                phase_d     = 3'd0;
                dir_d       = 1'b0;
                changed_d   = 1'b0;
                sweep_cnt_d = 8'd0;
            end
            S_SWEEP: begin
                phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
                if (phase_q == 3'd0) begin
                    self_d = nb_val;
                    min_d  = 8'hFF;
                end else if (phase_q != 3'd5) begin
                    min_d = (nb_val < min_q) ? nb_val : min_q;
                end else begin
                    if (wr_now) begin
                        mem_we    = 1'b1;
                        mem_waddr = {build_bank, tile_y_q, tile_x_q};
                        mem_wdata = new_val;
                        changed_d = 1'b1;
                    end
                    if (tile_is_last) begin
                        // The next sweep runs the other way and starts on the
                        // tile this one ended on, so the tile does not move.
                        if (!stop_sweeps) begin
                            dir_d       = ~dir_q;
                            changed_d   = 1'b0;
                            sweep_cnt_d = sweep_cnt_q + 8'd1;
                        end
                    end else if (!dir_q) begin
                        if (tile_x_q == X_LAST) begin
                            tile_x_d = 6'd0;
                            tile_y_d = tile_y_q + 5'd1;
                        end else begin
                            tile_x_d = tile_x_q + 6'd1;
                        end
                    end else begin
                        if (tile_x_q == 6'd0) begin
                            tile_x_d = X_LAST;
                            tile_y_d = tile_y_q - 5'd1;
                        end else begin
                            tile_x_d = tile_x_q - 6'd1;
                        end
                    end
                end
            end
            S_SWAP: begin
                rd_bank_d    = build_bank;
                rd_seed_x_d  = seed_x_q;
                rd_seed_y_d  = seed_y_q;
                ready_d      = 1'b1;
                build_done_d = 1'b1;
                busy_d       = 1'b0;
            end
            default: ;
        endcase
    end

    // Read port. Masking uses the ghost tiles sampled together with the address.
    always_comb begin
        if (rdaddr_x >= X_END || rdaddr_y >= Y_END || !ready_q ||
            (rdaddr_x == prev_ghost1_x && rdaddr_y == prev_ghost1_y) ||
            (rdaddr_x == prev_ghost2_x && rdaddr_y == prev_ghost2_y))
            data_d = 8'hFF;
        else
            data_d = map_mem[{rd_bank_q, rdaddr_y, rdaddr_x}];
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            clr_cnt_q    <= 11'd0;
            seed_x_q     <= 6'd0;
            seed_y_q     <= 5'd0;
            rd_seed_x_q  <= 6'd0;
            rd_seed_y_q  <= 5'd0;
            tile_x_q     <= 6'd0;
            tile_y_q     <= 5'd0;
            phase_q      <= 3'd0;
            dir_q        <= 1'b0;
            changed_q    <= 1'b0;
            sweep_cnt_q  <= 8'd0;
            self_q       <= 8'hFF;
            min_q        <= 8'hFF;
            rd_bank_q    <= 1'b0;
            data_q       <= 8'hFF;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            build_done_q <= 1'b0;
        end else begin
            clr_cnt_q    <= clr_cnt_d;
            seed_x_q     <= seed_x_d;
            seed_y_q     <= seed_y_d;
            rd_seed_x_q  <= rd_seed_x_d;
            rd_seed_y_q  <= rd_seed_y_d;
            tile_x_q     <= tile_x_d;
            tile_y_q     <= tile_y_d;
            phase_q      <= phase_d;
            dir_q        <= dir_d;
            changed_q    <= changed_d;
            sweep_cnt_q  <= sweep_cnt_d;
            self_q       <= self_d;
            min_q        <= min_d;
            rd_bank_q    <= rd_bank_d;
            data_q       <= data_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            build_done_q <= build_done_d;
        end
    end

    // Map storage has no reset. Every build clears its bank before it is used.
    always_ff @(posedge CLOCK_50) begin
        if (mem_we) map_mem[mem_waddr] <= mem_wdata;
    end

    assign data       = data_q;
    assign ready      = ready_q;
    assign busy       = busy_q;
    assign build_done = build_done_q;
    assign wall_x     = tile_x_q;
    assign wall_y     = tile_y_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ghost_dist_map.sv
// Testbench for ghost_dist_map.
// A smaller grid keeps each build to a few thousand cycles. Expected distances
// come from a breadth-first search over the bench's own wall map.
module tb_ghost_dist_map;

    localparam int GW = 16;
    localparam int GH = 12;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_SWEEP = 3'd3;
    localparam logic [2:0] ST_SWAP  = 3'd4;

    logic       clk, rst_n;
    logic [5:0] pac_x, g1x, g2x, rdaddr_x, wall_x;
    logic [4:0] pac_y, g1y, g2y, rdaddr_y, wall_y;
    logic [7:0] data;
    logic       ready, busy, build_done, wall_in;
    logic [2:0] dbg_state;

    logic       wall_rom [0:2047];
    int         srv_m [0:GH-1][0:GW-1];
    int         bld_m [0:GH-1][0:GW-1];
    logic       m_ready;
    logic [7:0] exp_q [$];
    int         n_cmp, n_fail;

    ghost_dist_map #(.GRID_W(GW), .GRID_H(GH), .MAX_SWEEPS(64)) dut (
        .CLOCK_50(clk), .reset(rst_n),
        .curr_pacman_x(pac_x), .curr_pacman_y(pac_y),
        .prev_ghost1_x(g1x), .prev_ghost1_y(g1y),
        .prev_ghost2_x(g2x), .prev_ghost2_y(g2y),
        .rdaddr_x(rdaddr_x), .rdaddr_y(rdaddr_y),
        .data(data), .ready(ready), .busy(busy), .build_done(build_done),
        .wall_x(wall_x), .wall_y(wall_y), .wall_in(wall_in),
        .dbg_state(dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wall ROM: one-cycle registered lookup
    always @(posedge clk) wall_in <= wall_rom[{wall_y, wall_x}];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void bfs(input int sx, input int sy);
        int qx[$], qy[$];
        int cx, cy, nx, ny, d;
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) bld_m[y][x] = 255;
        bld_m[sy][sx] = 0;
        qx.push_back(sx); qy.push_back(sy);
        while (qx.size() > 0) begin
            cx = qx.pop_front(); cy = qy.pop_front();
            d = bld_m[cy][cx] + 1;
            if (d > 254) d = 254;
            for (int k = 0; k < 4; k++) begin
                nx = cx + ((k == 2) ? -1 : (k == 3) ? 1 : 0);
                ny = cy + ((k == 0) ? -1 : (k == 1) ? 1 : 0);
                if (nx >= 0 && nx < GW && ny >= 0 && ny < GH &&
                    !wall_rom[ny*64 + nx] && bld_m[ny][nx] == 255) begin
                    bld_m[ny][nx] = d;
                    qx.push_back(nx); qy.push_back(ny);
                end
            end
        end
    endfunction

    function automatic logic [7:0] model_data(input int x, input int y);
        if (x >= GW || y >= GH) return 8'hFF;
        if (x == int'(g1x) && y == int'(g1y)) return 8'hFF;
        if (x == int'(g2x) && y == int'(g2y)) return 8'hFF;
        if (!m_ready) return 8'hFF;
        return 8'(srv_m[y][x]);
    endfunction

    // Driver: present an address for one edge; the scoreboard pops on the next edge.
    task automatic rd(input int x, input int y);
        logic [7:0] e;
        @(negedge clk);
        rdaddr_x = 6'(x);
        rdaddr_y = 5'(y);
        exp_q.push_back(model_data(x, y));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_cmp++;
        assert (data === e) else begin
            n_fail++;
            $error("FAIL rd(%0d,%0d): got %0d expected %0d", x, y, data, e);
        end
    endtask

    task automatic read_all();
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) rd(x, y);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(posedge clk); #1;
            if (dbg_state == st) found = 1'b1;
        end
        check("wait_state", 32'(found), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(posedge clk); #1;
            if (build_done) found = 1'b1;
        end
        check("wait_build_done", 32'(found), 32'd1);
        srv_m   = bld_m;
        m_ready = 1'b1;
    endtask

    task automatic set_pac(input int x, input int y);
        @(negedge clk);
        pac_x = 6'(x);
        pac_y = 5'(y);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; m_ready = 1'b0;
        rst_n = 1'b0; wall_in = 1'b0;
        pac_x = 6'd8; pac_y = 5'd6;
        g1x = 6'd0; g1y = 5'd0; g2x = 6'd0; g2y = 5'd0;
        rdaddr_x = 6'd0; rdaddr_y = 5'd0;
        for (int i = 0; i < 2048; i++) wall_rom[i] = 1'b0;
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) srv_m[y][x] = 255;

        // Reset state
        #23;
        check("rst_data", 32'(data), 32'hFF);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_build_done", 32'(build_done), 32'd0);
        check("rst_wall_x", 32'(wall_x), 32'd0);
        check("rst_wall_y", 32'(wall_y), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // Open maze, pacman (8,6); the build starts on the first edge after release
        bfs(8, 6);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("start_busy", 32'(busy), 32'd1);
        check("start_state", 32'(dbg_state), 32'(ST_CLEAR));
        rd(5, 5);  // no completed map yet
        wait_done(30000);
        check("done_ready", 32'(ready), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("done_pulse_len", 32'(build_done), 32'd0);
        read_all();
        rd(45, 3); rd(16, 3); rd(3, 12); rd(63, 31);

        // Previous-ghost masking on both ghosts
        @(negedge clk); g1x = 6'd4; g1y = 5'd5;
        rd(4, 5); rd(4, 7);
        @(negedge clk); g1x = 6'd0; g1y = 5'd0;
        rd(4, 5);
        @(negedge clk); g2x = 6'd9; g2y = 5'd6;
        rd(9, 6); rd(10, 6);
        @(negedge clk); g2x = 6'd0; g2y = 5'd0;
        rd(9, 6);

        // Pacman moves mid-sweep: the first build finishes, then a rebuild follows
        bfs(3, 3);
        set_pac(3, 3);
        wait_state(ST_SWEEP, 4000);
        set_pac(4, 3);
        wait_done(30000);
        bfs(4, 3);
        check("swap_then_idle", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk); #1;
        check("restart_state", 32'(dbg_state), 32'(ST_CLEAR));
        check("restart_busy", 32'(busy), 32'd1);
        rd(3, 3); rd(4, 3);
        wait_state(ST_SWAP, 30000);
        rd(3, 3);  // sampled on the swap edge: still the old bank
        check("swap_pulse", 32'(build_done), 32'd1);
        srv_m = bld_m;
        rd(3, 3); rd(4, 3);
        read_all();

        // Wall column x=6, y=0..10 (gap at y=11); tile (12,2) fully enclosed
        @(negedge clk);
        for (int y = 0; y <= 10; y++) wall_rom[y*64 + 6] = 1'b1;
        wall_rom[2*64 + 11] = 1'b1; wall_rom[2*64 + 13] = 1'b1;
        wall_rom[1*64 + 12] = 1'b1; wall_rom[3*64 + 12] = 1'b1;
        bfs(9, 5);
        set_pac(9, 5);
        wait_done(30000);
        read_all();
        rd(6, 5); rd(12, 2); rd(5, 5);

        // Asynchronous reset between edges in the middle of a sweep
        set_pac(2, 9);
        wait_state(ST_SWEEP, 4000);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_data", 32'(data), 32'hFF);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        m_ready = 1'b0;
        for (int i = 0; i < 2048; i++) wall_rom[i] = 1'b0;
        pac_x = 6'd8; pac_y = 5'd6;
        bfs(8, 6);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        rd(8, 6);  // rebuild not finished
        wait_done(30000);
        read_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
